// File: rtl/d_fetch_queue.sv
// Decode-side fetch queue: buffers {pc, instr} pairs from the IFU and hands them to decode
// over a valid/ready handshake, back-pressuring the IFU PC and discarding entries on flush.
module d_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   f_instr,
  input  logic [31:0]   f_pc,
  output logic          f_we,
  input  logic          flush,
  output logic [31:0]   d_instr,
  output logic [31:0]   d_pc,
  output logic          d_valid,
  input  logic          d_ready,
  output logic [AW:0]   count
);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          push;
  logic          pop;

  // f_we depends only on registered count and flush, never on d_ready
  assign full    = (count == (AW+1)'(DEPTH));
  assign f_we    = ~reset & (flush | ~full);
  assign push    = f_we & ~flush;
  assign d_valid = (count != '0);
  assign pop     = d_valid & d_ready & ~flush;

  assign d_pc    = d_valid ? mem[rd_ptr][63:32] : 32'h0;
  assign d_instr = d_valid ? mem[rd_ptr][31:0]  : 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; outputs are gated by d_valid instead
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {f_pc, f_instr};
  end

endmodule

// File: tb/tb_d_fetch_queue.sv
// Directed testbench for d_fetch_queue: a bench-side IFU and a scoreboard queue predict
// f_we, count and the d_* head entry every cycle.
module tb_d_fetch_queue;

  logic        clk;
  logic        reset;
  logic [31:0] f_instr;
  logic [31:0] f_pc;
  logic        f_we;
  logic        flush;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [31:0] ifu_pc;
  logic [31:0] sb[$];
  logic        exp_we;

  d_fetch_queue #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .reset(reset), .f_instr(f_instr), .f_pc(f_pc), .f_we(f_we),
    .flush(flush), .d_instr(d_instr), .d_pc(d_pc), .d_valid(d_valid),
    .d_ready(d_ready), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {pc[15:0] ^ 16'hBEEF, pc[31:16] ^ 16'h0013};
  endfunction

  task automatic checkOutput(input string tag);
    logic        ev;
    logic [31:0] epc;
    logic [31:0] ein;
    logic [2:0]  ecnt;
    ev   = (sb.size() != 0);
    epc  = ev ? sb[0] : 32'h0;
    ein  = ev ? instr_of(sb[0]) : 32'h0;
    ecnt = 3'(sb.size());
    checks++;
    assert (f_we === exp_we) else begin
      errors++;
      $error("[TB] FAIL %s f_we observed=%0b expected=%0b", tag, f_we, exp_we);
    end
    checks++;
    assert (d_valid === ev) else begin
      errors++;
      $error("[TB] FAIL %s d_valid observed=%0b expected=%0b", tag, d_valid, ev);
    end
    checks++;
    assert (count === ecnt) else begin
      errors++;
      $error("[TB] FAIL %s count observed=%0d expected=%0d", tag, count, ecnt);
    end
    checks++;
    assert (d_pc === epc) else begin
      errors++;
      $error("[TB] FAIL %s d_pc observed=%h expected=%h", tag, d_pc, epc);
    end
    checks++;
    assert (d_instr === ein) else begin
      errors++;
      $error("[TB] FAIL %s d_instr observed=%h expected=%h", tag, d_instr, ein);
    end
  endtask

  // One clock: drive inputs, check the pre-edge state, then advance the IFU and scoreboard
  task automatic applyStimulus(input string tag, input logic r, input logic fl,
                               input logic rdy, input logic [31:0] npc);
    reset   = r;
    flush   = fl;
    d_ready = rdy;
    f_pc    = ifu_pc;
    f_instr = instr_of(ifu_pc);
    exp_we  = !r && (fl || sb.size() != 4);
    #1;
    checkOutput(tag);
    @(posedge clk);
    if (r) begin
      sb.delete();
      ifu_pc = 32'h3000;
    end else if (fl) begin
      sb.delete();
      ifu_pc = npc;
    end else begin
      if (sb.size() != 0 && rdy) void'(sb.pop_front());
      if (exp_we) begin
        sb.push_back(ifu_pc);
        ifu_pc = ifu_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; d_ready = 1'b0;
    ifu_pc = 32'h3000; f_pc = 32'h3000; f_instr = instr_of(32'h3000);
    exp_we = 1'b0;
    @(negedge clk);

    applyStimulus("reset0", 1'b1, 1'b0, 1'b1, 32'h0);
    applyStimulus("reset1", 1'b1, 1'b1, 1'b1, 32'h0);

    for (int i = 0; i < 4; i++) applyStimulus("stream", 1'b0, 1'b0, 1'b1, 32'h0);

    for (int i = 0; i < 6; i++) applyStimulus("fill", 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) applyStimulus("drain", 1'b0, 1'b0, 1'b1, 32'h0);

    for (int i = 0; i < 5; i++) applyStimulus("refill", 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("fullpop", 1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 2; i++) applyStimulus("afterpop", 1'b0, 1'b0, 1'b0, 32'h0);

    applyStimulus("flush0", 1'b0, 1'b1, 1'b0, 32'h3000);
    for (int i = 0; i < 3; i++) applyStimulus("to3", 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("flush3", 1'b0, 1'b1, 1'b1, 32'h3100);
    for (int i = 0; i < 3; i++) applyStimulus("redirect", 1'b0, 1'b0, 1'b1, 32'h0);

    for (int i = 0; i < 12; i++)
      applyStimulus("alt", 1'b0, 1'b0, logic'(i % 2), 32'h0);
    for (int i = 0; i < 20; i++)
      applyStimulus("rand", 1'b0, 1'b0, logic'($urandom_range(0, 1)), 32'h0);

    applyStimulus("preflush", 1'b0, 1'b1, 1'b0, 32'h3200);
    for (int i = 0; i < 2; i++) applyStimulus("to2", 1'b0, 1'b0, 1'b0, 32'h0);
    applyStimulus("rstflush", 1'b1, 1'b1, 1'b1, 32'h3300);
    applyStimulus("postrst", 1'b0, 1'b0, 1'b1, 32'h0);
    applyStimulus("postrst2", 1'b0, 1'b0, 1'b1, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
